// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between several requesters.
// Owns the per-device chip selects and the D/C line, with CS setup/hold/gap timing.
module spi_bus_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned CsSetupCycles = 2,
    parameter int unsigned CsHoldCycles  = 2,
    parameter int unsigned CsGapCycles   = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_valid_i,
    input  logic [NumReq*8-1:0]       req_data_i,
    input  logic [NumReq-1:0]         req_dc_i,
    input  logic [NumReq-1:0]         req_last_i,
    output logic [NumReq-1:0]         req_ready_o,
    output logic                      eng_valid_o,
    output logic [7:0]                eng_data_o,
    input  logic                      eng_ready_i,
    input  logic                      eng_done_i,
    output logic [NumReq-1:0]         cs_n_o,
    output logic                      dc_o,
    output logic                      busy_o,
    output logic [$clog2(NumReq)-1:0] owner_o
);

    localparam int unsigned OwnW = $clog2(NumReq);
    localparam int unsigned CntW = 4;

    typedef enum logic [2:0] {
        IDLE, SETUP, XFER, WAIT, HOLD, GAP
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [OwnW-1:0] ptr;
    logic            last_q;

    logic            grant_found;
    logic [OwnW-1:0] grant_idx;
    logic [OwnW-1:0] idx;
    logic            sel_valid;
    logic [7:0]      sel_data;
    logic            sel_dc;
    logic            sel_last;
    logic            load;

    // First valid requester at or after the pointer; scanning backwards lets the nearest win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = int'(NumReq) - 1; k >= 0; k--) begin
            idx = OwnW'((32'(ptr) + 32'(k)) % NumReq);
            if (req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_valid = req_valid_i[owner_o];
        sel_data  = req_data_i[{owner_o, 3'b000} +: 8];
        sel_dc    = req_dc_i[owner_o];
        sel_last  = req_last_i[owner_o];
    end

    // Offer register follows the owner whenever nothing is pending on the engine.
    always_comb begin
        load = 1'b0;
        case (state)
            SETUP:   load = (cnt == CntW'(CsSetupCycles - 1));
            XFER:    load = !eng_valid_o;
            WAIT:    load = eng_done_i && !last_q;
            default: load = 1'b0;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (state == XFER && eng_valid_o && eng_ready_i) begin
            req_ready_o[owner_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= '0;
            last_q      <= 1'b0;
            owner_o     <= '0;
            cs_n_o      <= '1;
            dc_o        <= 1'b0;
            eng_valid_o <= 1'b0;
            eng_data_o  <= 8'h00;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        owner_o <= grant_idx;
                        cs_n_o  <= ~(NumReq'(1) << grant_idx);
                        busy_o  <= 1'b1;
                        cnt     <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CntW'(CsSetupCycles - 1)) begin
                        state <= XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (eng_valid_o && eng_ready_i) begin
                        eng_valid_o <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_done_i) begin
                        cnt   <= '0;
                        state <= last_q ? HOLD : XFER;
                    end
                end
                HOLD: begin
                    if (cnt == CntW'(CsHoldCycles - 1)) begin
                        cs_n_o <= '1;
                        ptr    <= OwnW'((32'(owner_o) + 32'd1) % NumReq);
                        cnt    <= '0;
                        state  <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CntW'(CsGapCycles - 1)) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                eng_valid_o <= sel_valid;
                eng_data_o  <= sel_data;
                dc_o        <= sel_dc;
                last_q      <= sel_last;
            end
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter (NumReq=2, default timing) with a simple
// engine model (done 8 cycles after acceptance) and per-requester byte queues.
module tb_spi_bus_arbiter;

    localparam int unsigned N = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       dc;
        logic       last;
    } byte_t;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   req_valid_i;
    logic [N*8-1:0] req_data_i;
    logic [N-1:0]   req_dc_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           eng_valid_o;
    logic [7:0]     eng_data_o;
    logic           eng_ready_i;
    logic           eng_done_i;
    logic [N-1:0]   cs_n_o;
    logic           dc_o;
    logic           busy_o;
    logic [0:0]     owner_o;

    spi_bus_arbiter #(
        .NumReq(2), .CsSetupCycles(2), .CsHoldCycles(2), .CsGapCycles(1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_dc_i(req_dc_i), .req_last_i(req_last_i), .req_ready_o(req_ready_o),
        .eng_valid_o(eng_valid_o), .eng_data_o(eng_data_o),
        .eng_ready_i(eng_ready_i), .eng_done_i(eng_done_i),
        .cs_n_o(cs_n_o), .dc_o(dc_o), .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    int         checks = 0;
    int         failures = 0;
    byte_t      q0[$];
    byte_t      q1[$];
    logic [1:0] hold = '0;
    logic       eng_block = 1'b0;
    int         eng_cnt = 0;
    int         rdy_cnt[2] = '{0, 0};
    logic [7:0] acc_log[$];
    int         own_log[$];
    int         gap_log[$];
    int         hi_run = 0;
    logic [1:0] prev_cs = 2'b11;

    // One clock: drive requesters and engine just after the edge, sample mid-cycle.
    task automatic cyc();
        @(posedge clk_i);
        #1;
        if (q0.size() > 0 && !hold[0]) begin
            req_valid_i[0] = 1'b1; req_data_i[7:0] = q0[0].d;
            req_dc_i[0] = q0[0].dc; req_last_i[0] = q0[0].last;
        end else begin
            req_valid_i[0] = 1'b0;
        end
        if (q1.size() > 0 && !hold[1]) begin
            req_valid_i[1] = 1'b1; req_data_i[15:8] = q1[0].d;
            req_dc_i[1] = q1[0].dc; req_last_i[1] = q1[0].last;
        end else begin
            req_valid_i[1] = 1'b0;
        end
        eng_done_i = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) eng_done_i = 1'b1;
        end
        eng_ready_i = (eng_cnt == 0) && !eng_done_i && !eng_block;
        #3;
        checks++;
        if ($countones(~cs_n_o) > 1) begin
            failures++;
            $display("FAIL cs_onehot t=%0t cs_n=%b required at most one low", $time, cs_n_o);
        end
        if (eng_valid_o && eng_ready_i) begin
            eng_cnt = 8;
            acc_log.push_back(eng_data_o);
        end
        if (req_ready_o[0]) begin
            rdy_cnt[0]++;
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (req_ready_o[1]) begin
            rdy_cnt[1]++;
            if (q1.size() > 0) void'(q1.pop_front());
        end
        if (cs_n_o != 2'b11 && prev_cs == 2'b11) begin
            own_log.push_back(int'(owner_o));
            gap_log.push_back(hi_run);
        end
        if (cs_n_o == 2'b11) hi_run++;
        else hi_run = 0;
        prev_cs = cs_n_o;
    endtask

    task automatic drain(input int max_cycles, output bit ok);
        int n = 0;
        do begin
            cyc();
            n++;
        end while ((q0.size() + q1.size() > 0 || busy_o || eng_cnt > 0) && n < max_cycles);
        ok = !(q0.size() + q1.size() > 0 || busy_o || eng_cnt > 0);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        own_log.delete();
        gap_log.delete();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid_i = '0; req_data_i = '0; req_dc_i = '0; req_last_i = '0;
        eng_ready_i = 1'b0; eng_done_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #4;
        checks++;
        if (cs_n_o !== 2'b11 || dc_o !== 1'b0 || eng_valid_o !== 1'b0 || eng_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs cs_n=%b dc=%b valid=%b data=%h required 11 0 0 00",
                     cs_n_o, dc_o, eng_valid_o, eng_data_o);
        end
        checks++;
        if (req_ready_o !== 2'b00 || busy_o !== 1'b0 || owner_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_status ready=%b busy=%b owner=%b required 00 0 0",
                     req_ready_o, busy_o, owner_o);
        end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (3) cyc();
        checks++;
        if (busy_o !== 1'b0 || cs_n_o !== 2'b11 || eng_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b cs_n=%b valid=%b required 0 11 0",
                     busy_o, cs_n_o, eng_valid_o);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        clear_logs();
        q0.push_back({8'h11, 1'b1, 1'b1});
        q0.push_back({8'h12, 1'b1, 1'b1});
        q1.push_back({8'h21, 1'b1, 1'b1});
        q1.push_back({8'h22, 1'b1, 1'b1});
        drain(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rr_timeout busy=%b pending=%0d required idle and drained",
                     busy_o, q0.size() + q1.size());
        end
        checks++;
        if (own_log.size() != 4 || own_log[0] != 0 || own_log[1] != 1 ||
            own_log[2] != 0 || own_log[3] != 1) begin
            failures++;
            $display("FAIL rr_owners got %p required 0 1 0 1", own_log);
        end
        checks++;
        if (acc_log.size() != 4 || acc_log[0] != 8'h11 || acc_log[1] != 8'h21 ||
            acc_log[2] != 8'h12 || acc_log[3] != 8'h22) begin
            failures++;
            $display("FAIL rr_bytes got %p required 11 21 12 22", acc_log);
        end
        for (int i = 1; i < gap_log.size(); i++) begin
            checks++;
            if (gap_log[i] < 1) begin
                failures++;
                $display("FAIL rr_gap idx=%0d got %0d required >=1", i, gap_log[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [1:0] exp_cs;
        logic       exp_v;
        q0.push_back({8'hA5, 1'b0, 1'b0});
        q0.push_back({8'h3C, 1'b1, 1'b1});
        for (int k = 0; k <= 25; k++) begin
            cyc();
            exp_cs = (k >= 1 && k <= 22) ? 2'b10 : 2'b11;
            exp_v  = (k == 3 || k == 12);
            checks++;
            if (cs_n_o !== exp_cs) begin
                failures++;
                $display("FAIL single_cs k=%0d got %b required %b", k, cs_n_o, exp_cs);
            end
            checks++;
            if (eng_valid_o !== exp_v || req_ready_o !== {1'b0, exp_v}) begin
                failures++;
                $display("FAIL single_valid k=%0d got valid=%b ready=%b required %b", k,
                         eng_valid_o, req_ready_o, exp_v);
            end
            checks++;
            if (busy_o !== (k >= 1 && k <= 23)) begin
                failures++;
                $display("FAIL single_busy k=%0d got %b", k, busy_o);
            end
            if (k >= 3) begin
                checks++;
                if (eng_data_o !== ((k >= 12) ? 8'h3C : 8'hA5) || dc_o !== (k >= 12)) begin
                    failures++;
                    $display("FAIL single_data k=%0d got data=%h dc=%b required %h %b", k,
                             eng_data_o, dc_o, (k >= 12) ? 8'h3C : 8'hA5, k >= 12);
                end
            end
            if (k == 1) begin
                checks++;
                if (owner_o !== 1'b0) begin
                    failures++;
                    $display("FAIL single_owner got %b required 0", owner_o);
                end
            end
        end
    endtask

    task automatic test_contention();
        int  n = 0;
        int  bad = 0;
        int  r1 = rdy_cnt[1];
        clear_logs();
        q0.push_back({8'h31, 1'b0, 1'b0});
        q0.push_back({8'h32, 1'b1, 1'b0});
        q0.push_back({8'h33, 1'b1, 1'b1});
        q1.push_back({8'h41, 1'b1, 1'b1});
        hold[1] = 1'b1;
        do begin
            cyc();
            n++;
            if (!cs_n_o[0]) hold[1] = 1'b0;
            if (req_ready_o[1] && !cs_n_o[0]) bad++;
        end while ((q0.size() + q1.size() > 0 || busy_o || eng_cnt > 0) && n < 300);
        checks++;
        if (bad != 0 || n >= 300) begin
            failures++;
            $display("FAIL contention_ready1 stray=%0d cycles=%0d required 0 stray, drained", bad, n);
        end
        checks++;
        if (acc_log.size() != 4 || acc_log[0] != 8'h31 || acc_log[1] != 8'h32 ||
            acc_log[2] != 8'h33 || acc_log[3] != 8'h41) begin
            failures++;
            $display("FAIL contention_bytes got %p required 31 32 33 41", acc_log);
        end
        checks++;
        if (own_log.size() != 2 || own_log[0] != 0 || own_log[1] != 1 || gap_log[1] != 2) begin
            failures++;
            $display("FAIL contention_order owners=%p gaps=%p required owners 0 1, gap 2",
                     own_log, gap_log);
        end
        checks++;
        if (rdy_cnt[1] - r1 != 1) begin
            failures++;
            $display("FAIL contention_pulses got %0d required 1", rdy_cnt[1] - r1);
        end
    endtask

    task automatic test_stall();
        logic exp_v;
        q0.push_back({8'h51, 1'b0, 1'b0});
        q0.push_back({8'h52, 1'b1, 1'b1});
        for (int k = 0; k <= 38; k++) begin
            hold[0] = (k >= 4 && k <= 23);
            cyc();
            exp_v = (k == 3 || k == 25);
            checks++;
            if (cs_n_o[0] !== !(k >= 1 && k <= 35)) begin
                failures++;
                $display("FAIL stall_cs k=%0d got %b", k, cs_n_o);
            end
            checks++;
            if (eng_valid_o !== exp_v) begin
                failures++;
                $display("FAIL stall_valid k=%0d got %b required %b", k, eng_valid_o, exp_v);
            end
            if (k == 25) begin
                checks++;
                if (eng_data_o !== 8'h52 || dc_o !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_resume got data=%h dc=%b required 52 1", eng_data_o, dc_o);
                end
            end
        end
        hold[0] = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_end busy got %b required 0", busy_o);
        end
    endtask

    task automatic test_backpressure();
        int r0 = rdy_cnt[0];
        q0.push_back({8'h61, 1'b1, 1'b1});
        for (int k = 0; k <= 21; k++) begin
            eng_block = (k >= 3 && k <= 7);
            cyc();
            if (k >= 3 && k <= 8) begin
                checks++;
                if (eng_valid_o !== 1'b1 || eng_data_o !== 8'h61 || dc_o !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold k=%0d got valid=%b data=%h dc=%b required 1 61 1", k,
                             eng_valid_o, eng_data_o, dc_o);
                end
            end
            checks++;
            if (req_ready_o[0] !== (k == 8)) begin
                failures++;
                $display("FAIL bp_ready k=%0d got %b required %b", k, req_ready_o[0], k == 8);
            end
        end
        eng_block = 1'b0;
        checks++;
        if (rdy_cnt[0] - r0 != 1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_end pulses=%0d busy=%b required 1 0", rdy_cnt[0] - r0, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        q0.push_back({8'h71, 1'b0, 1'b1});
        for (int k = 0; k <= 5; k++) cyc();
        checks++;
        if (cs_n_o !== 2'b10 || eng_valid_o !== 1'b0 || eng_data_o !== 8'h71) begin
            failures++;
            $display("FAIL rmid_pre got cs_n=%b valid=%b data=%h required 10 0 71",
                     cs_n_o, eng_valid_o, eng_data_o);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if (cs_n_o !== 2'b11 || eng_valid_o !== 1'b0 || busy_o !== 1'b0 || dc_o !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async got cs_n=%b valid=%b busy=%b dc=%b required 11 0 0 0",
                     cs_n_o, eng_valid_o, busy_o, dc_o);
        end
        q0.delete(); q1.delete();
        eng_cnt = 0; req_valid_i = '0; eng_done_i = 1'b0; eng_ready_i = 1'b0;
        prev_cs = 2'b11; hi_run = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        clear_logs();
        q0.push_back({8'h90, 1'b1, 1'b1});
        q1.push_back({8'h91, 1'b1, 1'b1});
        drain(200, ok);
        checks++;
        if (!ok || own_log.size() != 2 || own_log[0] != 0 || own_log[1] != 1) begin
            failures++;
            $display("FAIL rmid_pointer owners=%p ok=%b required 0 1", own_log, ok);
        end
        q1.push_back({8'h81, 1'b1, 1'b1});
        drain(200, ok);
        checks++;
        if (!ok || own_log.size() != 3 || own_log[2] != 1 || acc_log.size() != 3 ||
            acc_log[2] != 8'h81) begin
            failures++;
            $display("FAIL rmid_req1 owners=%p bytes=%p ok=%b required owner 1 byte 81",
                     own_log, acc_log, ok);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_contention();
        test_stall();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single user-domain SPI byte engine (SCK/MOSI serializer) between several requesters, e.g. the SSD1331 OLED frame pusher and the ADXL345 poller.
- Grants the bus per transaction with round-robin priority.
- Owns the per-device active-low chip selects and the OLED data/command line, with CS setup, hold and gap timing.
- Sits between the requesters and the byte engine inside the user domain. Its cs_n and dc outputs replace direct register-driven CS/DC.

Parameters:
- NumReq, 2, number of requesters. Index i drives cs_n_o[i]. Range 2..4.
- CsSetupCycles, 2, cycles CS is low before the first byte is offered. Range 1..15.
- CsHoldCycles, 2, cycles CS stays low after the last byte's done. Range 1..15.
- CsGapCycles, 1, minimum cycles all CS are high between transactions. Range 1..15.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  requester i has a byte pending
- req_data_i  in  NumReq*8  byte of requester i, at bits [8i+7:8i]
- req_dc_i  in  NumReq  D/C value for that byte: 1 = data, 0 = command
- req_last_i  in  NumReq  byte is the last of the transaction
- req_ready_o  out  NumReq  one-cycle pulse when requester i's byte is accepted by the engine
- eng_valid_o  out  1  byte offered to the engine
- eng_data_o  out  8  byte to the engine
- eng_ready_i  in  1  engine idle and able to accept
- eng_done_i  in  1  one-cycle pulse when the engine has finished shifting the byte
- cs_n_o  out  NumReq  chip selects, active low
- dc_o  out  1  data/command line
- busy_o  out  1  a transaction is in progress (state is not IDLE)
- owner_o  out  $clog2(NumReq)  index of the current or last owner

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - cs_n_o all ones; dc_o=0; eng_valid_o=0; eng_data_o=0.
  - req_ready_o all zero; busy_o=0; owner_o=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - State=IDLE.
- All outputs are registered, except req_ready_o, which is eng_valid_o & eng_ready_i gated to the owner bit.
- States: IDLE, SETUP, XFER, WAIT, HOLD, GAP.
- IDLE:
  - If any req_valid_i is set, grant the first set requester at or after the pointer (wrapping). Latch owner_o.
  - Go to SETUP; cs_n_o[owner] falls on entry.
- SETUP: count CsSetupCycles cycles, then go to XFER.
- XFER:
  - eng_valid_o = req_valid_i[owner]; eng_data_o and dc_o follow the owner's inputs.
  - On eng_valid_o & eng_ready_i, the byte is accepted: pulse req_ready_o[owner], latch last, and go to WAIT.
  - dc_o and eng_data_o then stay frozen until done.
- WAIT:
  - eng_valid_o=0.
  - On eng_done_i: go to HOLD if the latched last=1, else go to XFER. CS stays low in either case.
  - A new req_valid_i arriving in the same cycle as eng_done_i is offered the following cycle.
- HOLD: count CsHoldCycles cycles, then raise cs_n_o[owner]. Set pointer = (owner+1) mod NumReq. Go to GAP.
- GAP: all CS high for CsGapCycles cycles, then go to IDLE. Requests are not sampled during GAP.
- Latency: a request sampled in IDLE at cycle 0 gives cs_n low at cycle 1 and eng_valid_o first high at cycle 1+CsSetupCycles.
- Only the owner's signals are observed mid-transaction:
  - Other requesters' valid bits wait; they are never dropped and never receive a ready pulse.
  - The owner may deassert valid between bytes. CS is then held low indefinitely until a byte with last=1 completes.
- Never more than one cs_n_o bit is low. dc_o is don't-care-stable, holding its last value, outside XFER/WAIT.
- eng_done_i outside WAIT is ignored. eng_ready_i outside XFER is ignored.
- Single-byte transaction: a byte with last=1 in the first XFER goes straight to HOLD after its done.
- Reset asserted mid-transaction: immediate asynchronous return to reset values, so CS rises at once. The pointer returns to 0.

Test Plan:
- Single request, NumReq=2, defaults: req0 sends bytes 0xA5 (dc=0), then 0x3C (dc=1, last), with the engine done 8 cycles after acceptance → cs_n_o=2'b10 from cycle 1; eng_valid_o at cycle 3; eng_data_o=0xA5 with dc_o=0 until done; then 0x3C with dc_o=1; cs_n rises 2 cycles after the second done; busy_o falls after 1 GAP cycle.
- Round robin: req0 and req1 both valid in IDLE with single-byte transactions, repeated → owner sequence 0,1,0,1; cs_n_o never 2'b00; at least 1 cycle with cs_n_o=2'b11 between owners.
- Contention mid-transaction: req1 raises valid while req0 is in a 3-byte transaction → req_ready_o[1] stays 0; req1 is granted only after req0's HOLD+GAP; req1's data is unchanged.
- Owner stall: req0 drops valid for 20 cycles between bytes 1 and 2 → cs_n_o[0] stays low; eng_valid_o=0 during the stall; transfer resumes the cycle after valid returns.
- Engine backpressure: eng_ready_i=0 for 5 cycles in XFER → eng_valid_o, eng_data_o and dc_o held stable; req_ready_o pulses exactly once, when eng_ready_i rises.
- Reset mid-transfer: assert rst_ni=0 in WAIT → cs_n_o=all ones and eng_valid_o=0 asynchronously; after release, a req1-only request is granted as owner 1 and the pointer behaviour restarts from 0.
